// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// multi-cycle FSM states and the forwarding priority helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

  // The memory stage holds the younger result, so it wins over writeback.
  function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
    fwd_pick = hit_m ? FWD_M : (hit_w ? FWD_W : FWD_RF);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: hold at all-ones once reached.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use bubbles, redirect
// flushes and a watchdog-guarded multi-cycle execute sequencer.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WIDTH      = 5,
  parameter int CNT_WIDTH  = 16,
  parameter int MC_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     Rs1D,
  input  logic [WIDTH-1:0]     Rs2D,
  input  logic [WIDTH-1:0]     Rs1E,
  input  logic [WIDTH-1:0]     Rs2E,
  input  logic [WIDTH-1:0]     RdE,
  input  logic [WIDTH-1:0]     RdM,
  input  logic [WIDTH-1:0]     RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemReadE,
  input  logic                 PCSrcE,
  input  logic                 McStartE,
  input  logic                 McDoneE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushM,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 McErr,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  localparam int WD_W = $clog2(MC_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

  mc_state_t       state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            mc_stall_s, timeout_s, lu_s;

  // Operand forwarding selects; register x0 is never forwarded.
  always_comb begin
    ForwardAE = fwd_pick(RegWriteM && (RdM != '0) && (RdM == Rs1E),
                         RegWriteW && (RdW != '0) && (RdW == Rs1E));
    ForwardBE = fwd_pick(RegWriteM && (RdM != '0) && (RdM == Rs2E),
                         RegWriteW && (RdW != '0) && (RdW == Rs2E));
  end

  assign lu_s      = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign timeout_s = (state_q == BUSY) && (wd_q == WD_LAST);

  // Multi-cycle sequencer next state, watchdog and stall request.
  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    err_d      = err_q;
    mc_stall_s = 1'b0;
    case (state_q)
      RUN: begin
        if (McStartE && !McDoneE) begin
          state_d    = BUSY;
          wd_d       = '0;
          mc_stall_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      BUSY: begin
        if (McDoneE) begin
          state_d = RUN;
        end else if (timeout_s) begin
          state_d = RUN;
          err_d   = 1'b1;
        end else begin
          wd_d       = wd_q + WD_W'(1);
          mc_stall_s = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Stall/flush controls: mc stall beats redirect, redirect beats load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (!rst_n) begin
      StallF = 1'b0;
    end else if (mc_stall_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lu_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = 1'b0;
    end
  end

  // FSM, watchdog and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign McErr = err_q;

  sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (StallF),
    .cnt_o (StallCount)
  );

  sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (FlushD || FlushE),
    .cnt_o (FlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle expected control vectors are
// queued when stimulus is driven and popped when the outputs are sampled.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int WIDTH      = 5;
  localparam int CNT_WIDTH  = 4;
  localparam int MC_TIMEOUT = 8;

  logic clk, rst_n;
  logic [WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, MemReadE, PCSrcE, McStartE, McDoneE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, McErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_WIDTH-1:0] StallCount, FlushCount;

  int vectors = 0;
  int miscompares = 0;
  logic [10:0] exp_q[$];

  hazard_ctrl #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .MC_TIMEOUT(MC_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .McStartE(McStartE), .McDoneE(McDoneE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .McErr(McErr),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, required reaching summary");
    $fatal(1);
  end

  function automatic logic [10:0] obs();
    return {StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, McErr};
  endfunction

  function automatic logic [10:0] mk(input logic sf, input logic sd, input logic se,
                                     input logic fd, input logic fe, input logic fm,
                                     input logic [1:0] ae, input logic [1:0] be,
                                     input logic err);
    return {sf, sd, se, fd, fe, fm, ae, be, err};
  endfunction

  task automatic idle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemReadE = 1'b0; PCSrcE = 1'b0;
    McStartE = 1'b0; McDoneE = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] got, e;
    rst_n = 1'b0;
    idle();
    McStartE = 1'b1; MemReadE = 1'b1; RdE = 5'd3; Rs1D = 5'd3; PCSrcE = 1'b1;
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL reset_ctrl: got %b expected %b", got, e);
      end
      vectors++;
      if (StallCount !== 4'd0 || FlushCount !== 4'd0) begin
        miscompares++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", StallCount, FlushCount);
      end
      @(posedge clk); #1;
    end
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    int t [7][8] = '{
      '{5, 0, 5, 5, 1, 1, 2, 0},
      '{5, 0, 0, 5, 1, 1, 1, 0},
      '{5, 7, 9, 7, 1, 1, 0, 1},
      '{7, 7, 7, 7, 0, 1, 1, 1},
      '{0, 0, 0, 0, 1, 1, 0, 0},
      '{3, 3, 3, 3, 1, 0, 2, 2},
      '{31, 4, 31, 4, 1, 1, 2, 1}};
    logic [10:0] got, e;
    for (int i = 0; i < 7; i++) begin
      idle();
      Rs1E = WIDTH'(t[i][0]); Rs2E = WIDTH'(t[i][1]); RdM = WIDTH'(t[i][2]); RdW = WIDTH'(t[i][3]);
      RegWriteM = (t[i][4] != 0); RegWriteW = (t[i][5] != 0);
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'(t[i][6]), 2'(t[i][7]), 1'b0));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL forward[%0d]: got %b expected %b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [10:0] got, e;
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin MemReadE = 1'b1; RdE = 5'd3; Rs2D = 5'd3;
             exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0)); end
        1: begin RdM = 5'd3; RegWriteM = 1'b1; Rs2E = 5'd3;
             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0)); end
        2: begin MemReadE = 1'b1; RdE = 5'd3; Rs2D = 5'd3; PCSrcE = 1'b1;
             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0)); end
        3: begin MemReadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0)); end
        4: begin MemReadE = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
             exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0)); end
        default: begin RdE = 5'd9; Rs1D = 5'd9;
             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0)); end
      endcase
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL load_use[%0d]: got %b expected %b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multicycle();
    logic [10:0] got, e;
    logic st;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      idle();
      McStartE = (c == 0) || (c == 5);
      McDoneE  = (c == 4) || (c == 5);
      PCSrcE   = (c == 2);
      if (c == 1) begin MemReadE = 1'b1; RdE = 5'd3; Rs1D = 5'd3; end
      st = (c < 4);
      exp_q.push_back(mk(st, st, st, 1'b0, 1'b0, st, 2'b00, 2'b00, 1'b0));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL multicycle[%0d]: got %b expected %b", c, got, e);
      end
      if (c == 6) begin
        vectors++;
        if (StallCount !== 4'd4 || FlushCount !== 4'd0) begin
          miscompares++; $display("FAIL mc_counts: got %0d/%0d expected 4/0", StallCount, FlushCount);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [10:0] got, e;
    logic st, fl;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      idle();
      McStartE = (c == 0);
      PCSrcE   = (c == 10);
      st = (c < MC_TIMEOUT);
      fl = (c == 10);
      exp_q.push_back(mk(st, st, st, fl, fl, st, 2'b00, 2'b00, (c >= MC_TIMEOUT + 1)));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL timeout[%0d]: got %b expected %b", c, got, e);
      end
      if (c == 11) begin
        vectors++;
        if (StallCount !== 4'd8 || FlushCount !== 4'd1) begin
          miscompares++; $display("FAIL to_counts: got %0d/%0d expected 8/1", StallCount, FlushCount);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [10:0] got, e;
    for (int c = 0; c < 3; c++) begin
      idle();
      McStartE = (c == 0);
      exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL busy_pre[%0d]: got %b expected %b", c, got, e);
      end
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
    got = obs(); e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++; $display("FAIL async_drop: got %b expected %b", got, e);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
    @(negedge clk);
    got = obs(); e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++; $display("FAIL post_reset: got %b expected %b", got, e);
    end
    vectors++;
    if (StallCount !== 4'd0 || FlushCount !== 4'd0) begin
      miscompares++; $display("FAIL post_reset_cnt: got %0d/%0d expected 0/0", StallCount, FlushCount);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [10:0] got, e;
    logic lu;
    logic [CNT_WIDTH-1:0] want;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      idle();
      lu = (c < 19);
      if (lu) begin MemReadE = 1'b1; RdE = 5'd3; Rs1D = 5'd3; end
      exp_q.push_back(mk(lu, lu, 1'b0, 1'b0, lu, 1'b0, 2'b00, 2'b00, 1'b0));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL sat_ctrl[%0d]: got %b expected %b", c, got, e);
      end
      if (c == 5 || c == 15 || c == 19) begin
        want = (c == 5) ? 4'd5 : 4'd15;
        vectors++;
        if (StallCount !== want || FlushCount !== want) begin
          miscompares++;
          $display("FAIL sat_cnt[%0d]: got %0d/%0d expected %0d/%0d", c, StallCount, FlushCount, want, want);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_forward();
    test_load_use();
    test_multicycle();
    test_timeout();
    test_reset_mid_busy();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
